// File: rtl/mips_prog_loader.sv
// mips_prog_loader: byte-stream to instruction-memory loader that holds the core in reset until the image is in.
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the data words.
module mips_prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic              i_reload,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [31:0]       o_im_wd,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_err
);
  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    RUN, ERR
  } state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
  logic [7:0] cks_q;
`else
  localparam state_t FIN = RUN;
`endif
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;
  state_t            state_q;
  logic [15:0]       n_q, widx_q;
  logic [1:0]        bcnt_q;
  logic [23:0]       asm_q;
  logic              we_q, core_q, rel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wd_q;
  logic [15:0]       n_new, widx_nx;
  assign n_new        = {n_q[7:0], i_s_data};
  assign widx_nx      = widx_q + 16'd1;
  assign o_busy       = (state_q != RUN) && (state_q != ERR);
  assign o_s_ready    = o_busy;
  assign o_err        = state_q == ERR;
  assign o_core_rst_n = core_q;
  assign o_im_we      = we_q;
  assign o_im_addr    = addr_q;
  assign o_im_wd      = wd_q;
  // Release is delayed two edges past the final data byte so the last write lands first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LEN_HI;
      n_q     <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      core_q  <= 1'b0;
      rel_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if ((state_q == RUN || state_q == ERR) && i_reload) begin
        state_q <= LEN_HI;
        widx_q  <= '0;
        bcnt_q  <= '0;
        core_q  <= 1'b0;
        rel_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        cks_q   <= '0;
`endif
      end else begin
        case (state_q)
          LEN_HI: if (i_s_valid) begin
            n_q     <= {8'h00, i_s_data};
            state_q <= LEN_LO;
          end
          LEN_LO: if (i_s_valid) begin
            n_q <= n_new;
            if (n_new == 16'd0) state_q <= FIN;
            else if ({1'b0, n_new} > CAP) state_q <= ERR;
            else state_q <= DATA;
          end
          DATA: if (i_s_valid) begin
            asm_q  <= {asm_q[15:0], i_s_data};
            bcnt_q <= bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            cks_q  <= cks_q ^ i_s_data;
`endif
            if (bcnt_q == 2'd3) begin
              we_q   <= 1'b1;
              wd_q   <= {asm_q, i_s_data};
              addr_q <= widx_q[ADDR_W-1:0];
              widx_q <= widx_nx;
              if (widx_nx == n_q) state_q <= FIN;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHK: if (i_s_valid) begin
            if (i_s_data == cks_q) begin
              state_q <= RUN;
              core_q  <= 1'b1;
            end else state_q <= ERR;
          end
`endif
          RUN: if (!core_q) begin
            rel_q  <= 1'b1;
            core_q <= rel_q;
          end
          ERR: core_q <= 1'b0;
          default: state_q <= LEN_HI;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: directed streams with a write scoreboard checked by an independent monitor.
module tb_mips_prog_loader;
  localparam int AW = 8;
  logic          i_clk = 1'b0, i_rst_n = 1'b0, i_s_valid = 1'b0, i_reload = 1'b0;
  logic [7:0]    i_s_data = 8'h00;
  logic          o_s_ready, o_im_we, o_core_rst_n, o_busy, o_err;
  logic [AW-1:0] o_im_addr;
  logic [31:0]   o_im_wd;
  int            errs = 0, checks = 0, we_cnt = 0, c0 = 0, t = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] e_m;
  logic [7:0]    stim[$];
  logic [31:0]   wq[$];

  mips_prog_loader #(.ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_s_data(i_s_data), .i_s_valid(i_s_valid),
    .o_s_ready(o_s_ready), .i_reload(i_reload), .o_im_we(o_im_we), .o_im_addr(o_im_addr),
    .o_im_wd(o_im_wd), .o_core_rst_n(o_core_rst_n), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (i_rst_n && o_im_we) begin
    we_cnt++;
    checks++;
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL im_write unexpected: addr=%0h wd=%08h", o_im_addr, o_im_wd);
    end else begin
      e_m = exp_q.pop_front();
      if ({o_im_addr, o_im_wd} !== e_m) begin
        errs++;
        $display("FAIL im_write: got addr=%0h wd=%08h expected addr=%0h wd=%08h",
                 o_im_addr, o_im_wd, e_m[AW+31:32], e_m[31:0]);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    chk("s_ready", int'(o_s_ready), 1);
    i_s_data  = b;
    i_s_valid = 1'b1;
    @(negedge i_clk);
    i_s_valid = 1'b0;
    i_s_data  = 8'hFF;
  endtask

  task automatic send(input bit gap);
    foreach (stim[i]) begin
      if (gap && i > 0) @(negedge i_clk);
      put(stim[i]);
    end
  endtask

  task automatic load(input bit gap);
    logic [15:0] n;
    logic [7:0]  x;
    n = 16'(wq.size());
    x = 8'h00;
    stim = {n[15:8], n[7:0]};
    foreach (wq[i]) begin
      for (int j = 3; j >= 0; j--) begin
        stim.push_back(wq[i][8*j +: 8]);
        x ^= wq[i][8*j +: 8];
      end
      exp_q.push_back({AW'(i), wq[i]});
    end
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(x);
`endif
    send(gap);
  endtask

  task automatic release_chk();
`ifdef LOADER_CHECKSUM_EN
    chk("core_rst_n_at_chk", int'(o_core_rst_n), 1);
`else
    chk("core_rst_n_k0", int'(o_core_rst_n), 0);
    @(negedge i_clk);
    chk("core_rst_n_k1", int'(o_core_rst_n), 0);
    @(negedge i_clk);
    chk("core_rst_n_k2", int'(o_core_rst_n), 1);
`endif
  endtask

  task automatic reload();
    i_reload = 1'b1;
    @(negedge i_clk);
    i_reload = 1'b0;
    chk("reload_core_rst_n", int'(o_core_rst_n), 0);
    chk("reload_busy", int'(o_busy), 1);
    chk("reload_err", int'(o_err), 0);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_ready"}, int'(o_s_ready), 1);
    chk({nm, "_we"}, int'(o_im_we), 0);
    chk({nm, "_addr"}, int'(o_im_addr), 0);
    chk({nm, "_wd"}, int'(o_im_wd), 0);
    chk({nm, "_core"}, int'(o_core_rst_n), 0);
    chk({nm, "_busy"}, int'(o_busy), 1);
    chk({nm, "_err"}, int'(o_err), 0);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    reset_vals("rst");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    wq = {32'h20080005, 32'h8C090004};
    c0 = we_cnt;
    load(1'b0);
    release_chk();
    chk("we_cycles", we_cnt - c0, 2);
    chk("run_ready", int'(o_s_ready), 0);
    chk("run_busy", int'(o_busy), 0);
    reload();
    c0 = we_cnt;
    load(1'b1);
    release_chk();
    chk("gap_we_cycles", we_cnt - c0, 2);
    reload();
    wq = {};
    load(1'b0);
    t = 0;
    while (!o_core_rst_n && t < 5) begin @(negedge i_clk); t++; end
    chk("n0_release", int'(o_core_rst_n), 1);
    chk("n0_err", int'(o_err), 0);
`ifdef LOADER_CHECKSUM_EN
    reload();
    stim = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    exp_q.push_back({AW'(0), 32'h12345678});
    send(1'b0);
    chk("cks_ok_core", int'(o_core_rst_n), 1);
    chk("cks_ok_err", int'(o_err), 0);
    reload();
    stim = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    exp_q.push_back({AW'(0), 32'h12345678});
    send(1'b0);
    chk("cks_bad_err", int'(o_err), 1);
    @(negedge i_clk);
    chk("cks_bad_core", int'(o_core_rst_n), 0);
`endif
    reload();
    c0 = we_cnt;
    stim = {8'h01, 8'h01};
    send(1'b0);
    chk("ovf_err", int'(o_err), 1);
    chk("ovf_ready", int'(o_s_ready), 0);
    chk("ovf_core", int'(o_core_rst_n), 0);
    @(negedge i_clk);
    chk("ovf_no_write", we_cnt - c0, 0);
    reload();
    stim = {8'h00, 8'h01, 8'h20, 8'h08};
    send(1'b0);
    c0 = we_cnt;
    i_rst_n = 1'b0;
    #1;
    reset_vals("abort");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("abort_no_write", we_cnt - c0, 0);
    wq = {32'h20080005};
    load(1'b0);
    release_chk();
    repeat (3) @(negedge i_clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Program loader sitting directly upstream of the single-cycle MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, writes them sequentially into instruction memory from word address 0, and holds the core in reset until the image is fully loaded. Once loading completes, it releases the core so fetch starts at PC 0 with a complete program.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words
- i_clk  input  1  core clock; all state changes on the rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_s_data  input  8  stream byte
- i_s_valid  input  1  byte on i_s_data is valid
- o_s_ready  output  1  loader can accept a byte; a byte transfers on a rising edge with i_s_valid & o_s_ready
- i_reload  input  1  single-cycle request to restart loading; honoured only in RUN or ERR
- o_im_we  output  1  instruction-memory write strobe, one cycle per word
- o_im_addr  output  ADDR_W  word address of the write
- o_im_wd  output  32  word to write
- o_core_rst_n  output  1  active-low reset to the core; low until a load completes cleanly
- o_busy  output  1  high in LEN_HI, LEN_LO, DATA and CHK
- o_err  output  1  high in ERR

Reset is asynchronous and active-low on i_rst_n. The clock is i_clk. Both are fixed.

## Operation
- Stream format: word count N (16 bits, high byte first), then N words of 4 bytes each, most significant byte first. With checksum enabled, one checksum byte follows the data.
- States:
  - LEN_HI: capture N[15:8] → LEN_LO.
  - LEN_LO: capture N[7:0].
    - If N = 0 → CHK when checksum is enabled, otherwise → RUN.
    - If N > 2^ADDR_W → ERR.
    - Otherwise → DATA.
  - DATA: shift each byte into a 32-bit assembly register and increment the 2-bit byte counter.
    - On the 4th byte, register the write: o_im_wd = assembled word, o_im_addr = word index, o_im_we = 1 for the next cycle. Increment the word index.
    - After word N-1 is written → CHK (checksum enabled) or RUN.
  - CHK: compare the received byte with the running checksum. Match → RUN; mismatch → ERR.
  - RUN: o_core_rst_n = 1, o_s_ready = 0. i_reload → LEN_HI.
  - ERR: o_core_rst_n = 0, o_s_ready = 0, o_err = 1. i_reload → LEN_HI.
- o_s_ready = 1 in LEN_HI, LEN_LO, DATA and CHK, with no bubbles; the block accepts one byte per cycle continuously.
- Entering LEN_HI via i_reload clears the word index, byte counter and checksum, and drives o_core_rst_n low in the same cycle the state changes.
- i_reload is ignored while o_busy is high.
- Words already written before an ERR stay in memory. The core is never released after an ERR.
- The word index is 16 bits internally. Only its low ADDR_W bits drive o_im_addr. N = 2^ADDR_W is legal, so the index reaches 2^ADDR_W without wrapping into a write.

## Timing
- Reset values: state LEN_HI, o_s_ready = 1, o_im_we = 0, o_im_addr = 0, o_im_wd = 0, o_core_rst_n = 0, o_busy = 1, o_err = 0.
- All outputs are registered or decoded from state only; nothing depends combinationally on i_s_valid or i_s_data.
- Write latency: if the 4th byte of a word transfers at edge k, o_im_we is high from edge k to edge k+1 and memory captures the word at edge k+1.
- Release: o_core_rst_n rises at the edge after the final write edge. Without checksum, that is edge k+2 relative to the last byte. With checksum, it rises at the edge the matching checksum byte transfers.
- i_rst_n asserted mid-load aborts immediately: all outputs return to reset values and the partial word is discarded.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHK state is present.
  - Checksum = 8-bit XOR of all data bytes, excluding the length bytes.
  - Mismatch → ERR.
- LOADER_CHECKSUM_EN undefined:
  - No CHK state and no checksum byte is expected.
  - The last data word goes straight to RUN.
  - ERR is reachable only via N > 2^ADDR_W.

## Test plan
- Reset, then stream 00 02 | 20 08 00 05 | 8C 09 00 04 → writes 0x20080005 @0 and 0x8C090004 @1; o_im_we is high exactly 2 cycles; o_core_rst_n rises 2 edges after the last byte.
- i_s_valid toggled 1-0-1 every byte on the same image → identical writes; no byte lost or duplicated; o_s_ready stays 1 until RUN.
- Length 01 01 with ADDR_W = 8 (N = 257) → ERR after the 2nd byte, o_err = 1, o_s_ready = 0, no write; i_reload → LEN_HI, o_err = 0.
- LOADER_CHECKSUM_EN defined, word 12 34 56 78 with checksum 0x08 → RUN. The same word with checksum 0x09 → ERR, and o_core_rst_n stays 0.
- In RUN, pulse i_reload → o_core_rst_n drops next edge; reload N = 0 → RUN with no writes (without the macro) or after one checksum byte 0x00 (with the macro).
- Assert i_rst_n low after 2 data bytes of word 0 → o_im_we never pulses; a restart from the length bytes loads correctly at address 0.
